// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_pkg
// Purpose  : Shared state encoding and 27 MHz timing defaults for the rPLL
//            lock/reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Defaults for a 27 MHz crystal clock
  localparam int C_SYNC_STAGES    = 2;
  localparam int C_PLL_RST_CYCLES = 27;      // 1 us
  localparam int C_LOCK_TIMEOUT   = 270000;  // 10 ms
  localparam int C_STABLE_CYCLES  = 2700;    // 100 us
  localparam int C_MAX_RETRIES    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Multi-flop synchronizer for a single asynchronous level signal.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Drives rPLL RESET, qualifies rPLL LOCK and releases the system
//            reset only after lock has been continuously stable.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = C_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = C_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = C_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = C_STABLE_CYCLES,
  parameter int MAX_RETRIES    = C_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o,
  output logic [7:0] lost_cnt_o
);

  localparam int CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       C_MAX_RETRY    = 8'(MAX_RETRIES);

  logic             w_lock_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_pll_reset;
  logic             r_sys_rst;
  logic             r_locked;
  logic             r_fault;
  logic             r_lock_lost;
  logic [7:0]       r_retry_cnt;
  logic [7:0]       r_lost_cnt;

  logic             w_lock_lost_nxt;
  logic [7:0]       w_retry_cnt_nxt;
  logic [7:0]       w_lost_cnt_nxt;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_i),
    .q   (w_lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry_cnt <= 8'd0;
      r_lost_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Outputs are registered from the next state so they change on the
      // same edge as the state itself.
      r_pll_reset <= (w_state_nxt == PLL_RST) || (w_state_nxt == FAULT);
      r_sys_rst   <= (w_state_nxt != RUN);
      r_locked    <= (w_state_nxt == RUN);
      r_fault     <= (w_state_nxt == FAULT);
      r_lock_lost <= w_lock_lost_nxt;
      r_retry_cnt <= w_retry_cnt_nxt;
      r_lost_cnt  <= w_lost_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lock_lost_nxt = 1'b0;
    w_retry_cnt_nxt = r_retry_cnt;
    w_lost_cnt_nxt  = r_lost_cnt;

    case (r_state)
      PLL_RST: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
        end
      end

      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over a retry.
        if (w_lock_s) begin
          w_state_nxt = STABLE;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_retry_cnt_nxt = r_retry_cnt + 8'd1;
          if (w_retry_cnt_nxt >= C_MAX_RETRY) begin
            w_state_nxt = FAULT;
          end else begin
            w_state_nxt = PLL_RST;
          end
        end
      end

      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt     = RUN;
          w_retry_cnt_nxt = 8'd0;
        end
      end

      RUN: begin
        // The rPLL relocks by itself, so a loss only re-holds system reset.
        if (!w_lock_s) begin
          w_state_nxt     = WAIT_LOCK;
          w_lock_lost_nxt = 1'b1;
          if (r_lost_cnt != 8'hFF) begin
            w_lost_cnt_nxt = r_lost_cnt + 8'd1;
          end
        end
      end

      FAULT: begin
        w_state_nxt = FAULT;
      end

      default: begin
        w_state_nxt = PLL_RST;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if ((r_state == PLL_RST) || (r_state == WAIT_LOCK) || (r_state == STABLE)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  assign pll_reset_o = r_pll_reset;
  assign sys_rst_o   = r_sys_rst;
  assign locked_o    = r_locked;
  assign fault_o     = r_fault;
  assign lock_lost_o = r_lock_lost;
  assign retry_cnt_o = r_retry_cnt;
  assign lost_cnt_o  = r_lost_cnt;

endmodule
`default_nettype wire
